// File: rtl/debug_pkg.sv
// Shared types and constants for the single-step register dump block.
package debug_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_STEP  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } dbg_state_e;

    localparam int unsigned FIRST_REG        = 32'd8;
    localparam int unsigned NUM_REGS         = 32'd8;
    localparam int unsigned CLKS_PER_BIT_DEF = 32'd4;

    // Register-file address of the idx-th dumped register.
    function automatic logic [3:0] reg_addr(input int unsigned first, input int unsigned idx);
        return 4'(first + idx);
    endfunction

endpackage

// File: rtl/debug_baud_gen.sv
// Bit-period counter: tick marks the last clock of each serial bit period.
module debug_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = debug_pkg::CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 32'd1) ? $clog2(CLKS_PER_BIT) : 32'd1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 32'd1);

    logic [CNT_W-1:0] cnt_r;

    // Counter restarts on clr and wraps after the last clock of a bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr || (cnt_r == CNT_LAST)) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign tick = ~clr & (cnt_r == CNT_LAST);

endmodule

// File: rtl/debug_reg_reader.sv
// Single-step controller: on a step request it advances the CPU one cycle, then
// dumps NUM_REGS register-file words as 8N1-style frames on a serial line.
module debug_reg_reader #(
    parameter int unsigned N            = 32'd24,
    parameter int unsigned CLKS_PER_BIT = debug_pkg::CLKS_PER_BIT_DEF,
    parameter int unsigned FIRST_REG    = debug_pkg::FIRST_REG,
    parameter int unsigned NUM_REGS     = debug_pkg::NUM_REGS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         dbg,
    input  logic         stp,
    output logic [3:0]   dbg_ra,
    input  logic [N-1:0] dbg_rd,
    output logic         cpu_en,
    output logic         out,
    output logic         busy,
    output logic         done
);
    import debug_pkg::*;

    localparam int unsigned IDX_W = (NUM_REGS > 32'd1) ? $clog2(NUM_REGS) : 32'd1;
    localparam int unsigned BIT_W = (N > 32'd1) ? $clog2(N) : 32'd1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 32'd1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 32'd1);

    dbg_state_e       state_r, state_nx_s;
    logic             stp_q_r;
    logic             step_edge_s;
    logic             tick_s;
    logic             clr_s;
    logic             done_s;
    logic [IDX_W-1:0] idx_r, idx_nx_s;
    logic [BIT_W-1:0] bit_cnt_r, bit_cnt_nx_s;
    logic [N-1:0]     shift_r, shift_nx_s;
    logic [3:0]       dbg_ra_r, dbg_ra_nx_s;
    logic             out_r, out_nx_s;
    logic             busy_r, busy_nx_s;

    assign step_edge_s = stp & ~stp_q_r;
    // Baud counter only runs while a bit is on the line, so each frame starts aligned.
    assign clr_s = (state_r != ST_START) && (state_r != ST_DATA) && (state_r != ST_STOP);

    debug_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .clr (clr_s),
        .tick(tick_s)
    );

    // Next-state, counters, shift register and next output values.
    always_comb begin
        state_nx_s   = state_r;
        idx_nx_s     = idx_r;
        bit_cnt_nx_s = bit_cnt_r;
        shift_nx_s   = shift_r;
        dbg_ra_nx_s  = dbg_ra_r;
        done_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (dbg && step_edge_s) begin
                    state_nx_s = ST_STEP;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_STEP: begin
                state_nx_s  = ST_LOAD;
                idx_nx_s    = '0;
                dbg_ra_nx_s = reg_addr(FIRST_REG, 32'd0);
            end
            ST_LOAD: begin
                state_nx_s   = ST_START;
                shift_nx_s   = dbg_rd;
                bit_cnt_nx_s = '0;
            end
            ST_START: begin
                if (tick_s) begin
                    state_nx_s = ST_DATA;
                end else begin
                    state_nx_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    shift_nx_s = shift_r >> 1;
                    if (bit_cnt_r == BIT_LAST) begin
                        state_nx_s = ST_STOP;
                    end else begin
                        bit_cnt_nx_s = bit_cnt_r + BIT_W'(1);
                    end
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    if (idx_r == IDX_LAST) begin
                        state_nx_s = ST_IDLE;
                        done_s     = 1'b1;
                    end else begin
                        state_nx_s  = ST_LOAD;
                        idx_nx_s    = idx_r + IDX_W'(1);
                        dbg_ra_nx_s = reg_addr(FIRST_REG, 32'(idx_r) + 32'd1);
                    end
                end else begin
                    state_nx_s = ST_STOP;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase

        // Line value is computed from the next state so the register lines up with it.
        case (state_nx_s)
            ST_START: out_nx_s = 1'b0;
            ST_DATA:  out_nx_s = shift_nx_s[0];
            default:  out_nx_s = 1'b1;
        endcase
        busy_nx_s = (state_nx_s != ST_IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            stp_q_r   <= 1'b0;
            idx_r     <= '0;
            bit_cnt_r <= '0;
            shift_r   <= '0;
            dbg_ra_r  <= reg_addr(FIRST_REG, 32'd0);
            out_r     <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            stp_q_r   <= stp;
            idx_r     <= idx_nx_s;
            bit_cnt_r <= bit_cnt_nx_s;
            shift_r   <= shift_nx_s;
            dbg_ra_r  <= dbg_ra_nx_s;
            out_r     <= out_nx_s;
            busy_r    <= busy_nx_s;
        end
    end

    // cpu_en follows dbg directly in IDLE so mode changes take effect without lag.
    assign cpu_en = ~rst & ((state_r == ST_STEP) | ((state_r == ST_IDLE) & ~dbg));
    assign done   = done_s;
    assign out    = out_r;
    assign busy   = busy_r;
    assign dbg_ra = dbg_ra_r;

endmodule

// File: tb/tb_debug_reg_reader.sv
// Directed bench for debug_reg_reader: table of dump scenarios plus reset/mode sequences.
module tb_debug_reg_reader;

    localparam int N     = 24;
    localparam int CPB   = 4;
    localparam int NREG  = 8;
    localparam int FRAME = 1 + (N + 2) * CPB;

    logic         clk = 1'b0;
    logic         rst;
    logic         dbg;
    logic         stp;
    logic [3:0]   dbg_ra;
    logic [N-1:0] dbg_rd;
    logic         cpu_en;
    logic         out;
    logic         busy;
    logic         done;

    logic [N-1:0] regfile [16];
    assign dbg_rd = regfile[dbg_ra];

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    debug_reg_reader #(
        .N(N),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .dbg   (dbg),
        .stp   (stp),
        .dbg_ra(dbg_ra),
        .dbg_rd(dbg_rd),
        .cpu_en(cpu_en),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    typedef struct {
        logic [NREG*N-1:0] words;   // frame f word at [f*N +: N]
        int                stp_a;   // dump cycle of an extra step pulse, -1 = none
        int                stp_b;
        int                dbg_off; // dump cycle where dbg drops, -1 = never
        logic              exp_idle_cpu_en;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected serial line level c cycles after the LOAD cycle of a frame.
    function automatic logic exp_bit(input logic [N-1:0] w, input int c);
        if (c == 0) return 1'b1;
        if (c <= CPB) return 1'b0;
        if (c <= CPB * (N + 1)) return w[(c - 1 - CPB) / CPB];
        return 1'b1;
    endfunction

    task automatic load_regs(input logic [NREG*N-1:0] words);
        for (int f = 0; f < NREG; f++) regfile[8 + f] = words[f*N +: N];
    endtask

    task automatic do_step(input string tag);
        @(negedge clk);
        stp = 1'b1;
        @(negedge clk);
        stp = 1'b0;
        check({tag, "_step_cpu_en"}, 64'(cpu_en), 64'd1);
        check({tag, "_step_busy"}, 64'(busy), 64'd1);
    endtask

    task automatic run_dump(input int vi, input vec_t v);
        int bad_line = 0;
        int en_hi = 0;
        int busy_cyc = 0;
        int done_cnt = 0;
        int done_at = -1;
        int bad_ra = 0;
        int idle_busy = 0;
        logic [N-1:0] dec;
        logic [N-1:0] w;
        for (int f = 0; f < NREG; f++) begin
            dec = '0;
            w = v.words[f*N +: N];
            for (int c = 0; c < FRAME; c++) begin
                int d;
                d = f * FRAME + c;
                @(negedge clk);
                if (out !== exp_bit(w, c)) bad_line++;
                if (c > CPB && c <= CPB * (N + 1) && ((c - 1 - CPB) % CPB) == 2)
                    dec[(c - 1 - CPB) / CPB] = out;
                if (c == 0 && dbg_ra !== 4'(8 + f)) bad_ra++;
                if (cpu_en !== 1'b0) en_hi++;
                if (busy === 1'b1) busy_cyc++;
                if (done !== 1'b0) begin
                    done_cnt++;
                    done_at = d;
                end
                stp = (d == v.stp_a) || (d == v.stp_b);
                if (d == v.dbg_off) dbg = 1'b0;
            end
            check($sformatf("v%0d_decode_f%0d", vi, f), 64'(dec), 64'(w));
        end
        check($sformatf("v%0d_line_errs", vi), 64'(bad_line), 64'd0);
        check($sformatf("v%0d_cpu_en_hi", vi), 64'(en_hi), 64'd0);
        check($sformatf("v%0d_busy_cycles", vi), 64'(busy_cyc), 64'(NREG * FRAME));
        check($sformatf("v%0d_done_cnt", vi), 64'(done_cnt), 64'd1);
        check($sformatf("v%0d_done_at", vi), 64'(done_at), 64'(NREG * FRAME - 1));
        check($sformatf("v%0d_dbg_ra_errs", vi), 64'(bad_ra), 64'd0);
        @(negedge clk);
        stp = 1'b0;
        check($sformatf("v%0d_idle_busy", vi), 64'(busy), 64'd0);
        check($sformatf("v%0d_idle_cpu_en", vi), 64'(cpu_en), 64'(v.exp_idle_cpu_en));
        check($sformatf("v%0d_idle_out", vi), 64'(out), 64'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (busy !== 1'b0) idle_busy++;
        end
        check($sformatf("v%0d_no_queued_step", vi), 64'(idle_busy), 64'd0);
    endtask

    initial begin
        int bad_en;
        int bad_out;
        int bad_busy;
        int post_busy;
        int post_done;

        vecs[0] = '{{24'hFEDCBA, 24'h0F0F0F, 24'hF0F0F0, 24'h000100,
                     24'h400000, 24'h000003, 24'hC00000, 24'h000001}, -1, -1, -1, 1'b0};
        vecs[1] = '{{24'h000007, 24'h7FFFFE, 24'h800001, 24'h123456,
                     24'h000000, 24'hFFFFFF, 24'h5A5A5A, 24'hA5A5A5}, -1, -1, -1, 1'b0};
        vecs[2] = '{{24'h111111, 24'h222222, 24'h333333, 24'h444444,
                     24'h555555, 24'h666666, 24'h777777, 24'h888888}, 50, 300, -1, 1'b0};
        vecs[3] = '{{24'hABCDEF, 24'h010203, 24'h0000FF, 24'hFF0000,
                     24'h00FF00, 24'h800000, 24'h000002, 24'h3C3C3C}, NREG * FRAME - 1, -1, -1, 1'b0};
        vecs[4] = '{{24'h13579B, 24'h2468AC, 24'hDEAD00, 24'h00BEEF,
                     24'hCAFE00, 24'h00F00D, 24'h999999, 24'h606060}, -1, -1, 5 * FRAME + 10, 1'b1};

        for (int i = 0; i < 16; i++) regfile[i] = '0;
        rst = 1'b1;
        dbg = 1'b0;
        stp = 1'b0;
        #2;
        check("rst_out", 64'(out), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cpu_en", 64'(cpu_en), 64'd0);
        check("rst_dbg_ra", 64'(dbg_ra), 64'd8);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Free-run mode, including a step pulse that must be ignored with dbg=0.
        bad_en = 0; bad_out = 0; bad_busy = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            stp = (k == 3);
            if (cpu_en !== 1'b1) bad_en++;
            if (out !== 1'b1) bad_out++;
            if (busy !== 1'b0) bad_busy++;
        end
        stp = 1'b0;
        check("free_cpu_en", 64'(bad_en), 64'd0);
        check("free_out", 64'(bad_out), 64'd0);
        check("free_busy", 64'(bad_busy), 64'd0);

        dbg = 1'b1;
        @(negedge clk);
        check("dbg_idle_cpu_en", 64'(cpu_en), 64'd0);

        for (int i = 0; i < 5; i++) begin
            dbg = 1'b1;
            load_regs(vecs[i].words);
            do_step($sformatf("v%0d", i));
            run_dump(i, vecs[i]);
        end

        // Reset in the middle of frame 3 aborts the dump without done.
        dbg = 1'b1;
        load_regs(vecs[1].words);
        do_step("rst_mid");
        for (int k = 0; k < 3 * FRAME + 20; k++) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_out", 64'(out), 64'd1);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_cpu_en", 64'(cpu_en), 64'd0);
        check("rst_mid_dbg_ra", 64'(dbg_ra), 64'd8);
        @(negedge clk);
        rst = 1'b0;
        post_busy = 0; post_done = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (busy !== 1'b0) post_busy++;
            if (done !== 1'b0) post_done++;
        end
        check("rst_mid_stays_idle", 64'(post_busy), 64'd0);
        check("rst_mid_no_done", 64'(post_done), 64'd0);
        do_step("restart");
        run_dump(9, vecs[1]);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
